// File: rtl/i2s_to_pcm_aligned_pkg.sv
// Shared constants, channel encoding and width helpers for the I2S to
// PCM1702 aligned converter.
package i2s_to_pcm_aligned_pkg;

  localparam int DAC_BITS_DEF    = 20;
  localparam int SLOT_BITS_DEF   = 32;
  localparam int LOCK_FRAMES_DEF = 2;

  // LRCK level encoding: low selects the left slot.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int frame_bits(input int slot_bits);
    return 2 * slot_bits;
  endfunction

endpackage

// File: rtl/i2s_to_pcm_aligned_if.sv
// Pin bundle between the I2S receiver, the converter and the two DACs.
// The master side drives the I2S pins and MUTE; the slave is the converter.
interface i2s_to_pcm_aligned_if;

  logic LRCK;
  logic DATAIN;
  logic MUTE;
  logic CLKOUTL;
  logic CLKOUTR;
  logic DATAOUTL;
  logic DATAOUTR;
  logic LEOUTL;
  logic LEOUTR;
  logic LOCKED;
  logic LED1;

  modport master (
    output LRCK, DATAIN, MUTE,
    input  CLKOUTL, CLKOUTR, DATAOUTL, DATAOUTR, LEOUTL, LEOUTR, LOCKED, LED1
  );

  modport slave (
    input  LRCK, DATAIN, MUTE,
    output CLKOUTL, CLKOUTR, DATAOUTL, DATAOUTR, LEOUTL, LEOUTR, LOCKED, LED1
  );

endinterface

// File: rtl/i2s_to_pcm_aligned_dac_serializer.sv
// One DAC channel: parallel load at frame start, MSB-first shift while
// enabled, zero on the line whenever not shifting.
module dac_serializer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             shift,
  output logic             dout
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
      dout <= 1'b0;
    end else if (load) begin
      sr_q <= word;
      dout <= 1'b0;
    end else if (shift) begin
      dout <= sr_q[WIDTH-1];
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end else begin
      dout <= 1'b0;
    end
  end

endmodule

// File: rtl/i2s_to_pcm_aligned.sv
// I2S deserialiser feeding two PCM1702-style DACs with a shared latch strobe,
// plus frame-sync checking, lock tracking and frame-boundary muting.
module i2s_to_pcm_aligned
  import i2s_to_pcm_aligned_pkg::*;
#(
  parameter int DAC_BITS    = DAC_BITS_DEF,
  parameter int SLOT_BITS   = SLOT_BITS_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic                  BCK,
  input  logic                  RSTN,
  i2s_to_pcm_aligned_if.slave   bus
);

  localparam int FRAME_BITS = frame_bits(SLOT_BITS);
  localparam int CNT_W      = clog2(FRAME_BITS);
  localparam int GOOD_W     = clog2(LOCK_FRAMES + 1);

  localparam logic [CNT_W-1:0]  LAST_CYC  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  RISE_PREV = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0]  L_FIRST   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  L_LAST    = CNT_W'(DAC_BITS);
  localparam logic [CNT_W-1:0]  R_FIRST   = CNT_W'(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0]  R_LAST    = CNT_W'(SLOT_BITS + DAC_BITS);
  localparam logic [CNT_W-1:0]  LE_CYC    = CNT_W'(DAC_BITS + 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FRAMES);

  i2s_ch_e              lrck_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 rise_ok_q;
  logic                 err_q;
  logic [GOOD_W-1:0]    good_q;
  logic [GOOD_W-1:0]    good_d;
  logic                 armed_q;
  logic                 le_n_q;
  logic                 le_n_d;
  logic [DAC_BITS-1:0]  cap_l_q;
  logic [DAC_BITS-1:0]  cap_r_q;
  logic [DAC_BITS-1:0]  word_l;
  logic [DAC_BITS-1:0]  word_r;
  logic                 rise;
  logic                 fall;
  logic                 frame_end;
  logic                 frame_good;
  logic                 pass_data;
  logic                 cap_l_en;
  logic                 cap_r_en;
  logic                 dout_l;
  logic                 dout_r;

  always_comb begin
    rise       = (lrck_q == CH_LEFT)  && (bus.LRCK == CH_RIGHT);
    fall       = (lrck_q == CH_RIGHT) && (bus.LRCK == CH_LEFT);
    // A missing fall closes the frame at the last cycle anyway, so the
    // counter never runs past one frame.
    frame_end  = fall || (cnt_q == LAST_CYC);
    cnt_d      = frame_end ? '0 : cnt_q + CNT_W'(1);
    frame_good = fall && (cnt_q == LAST_CYC) && rise_ok_q && !err_q;

    good_d = '0;
    if (frame_good) begin
      good_d = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
    end

    // Lock is judged with the frame that is closing now, so data flows on
    // the very frame boundary where LOCKED rises.
    pass_data = frame_good && (good_d == GOOD_MAX) && !bus.MUTE;
    word_l    = pass_data ? cap_l_q : '0;
    word_r    = pass_data ? cap_r_q : '0;

    cap_l_en = (cnt_d >= L_FIRST) && (cnt_d <= L_LAST);
    cap_r_en = (cnt_d >= R_FIRST) && (cnt_d <= R_LAST);
    le_n_d   = !(armed_q && (cnt_d == LE_CYC));
  end

  always_ff @(posedge BCK or negedge RSTN) begin
    if (!RSTN) begin
      lrck_q    <= CH_RIGHT;
      cnt_q     <= '0;
      rise_ok_q <= 1'b0;
      err_q     <= 1'b0;
      good_q    <= '0;
      armed_q   <= 1'b0;
      le_n_q    <= 1'b1;
      cap_l_q   <= '0;
      cap_r_q   <= '0;
    end else begin
      lrck_q <= i2s_ch_e'(bus.LRCK);
      cnt_q  <= cnt_d;
      le_n_q <= le_n_d;

      if (frame_end) begin
        rise_ok_q <= 1'b0;
        err_q     <= rise;
        good_q    <= good_d;
        if (good_d != '0) armed_q <= 1'b1;
      end else if (rise) begin
        if (cnt_q == RISE_PREV) rise_ok_q <= 1'b1;
        else                    err_q     <= 1'b1;
      end

      if (cap_l_en) cap_l_q <= {cap_l_q[DAC_BITS-2:0], bus.DATAIN};
      if (cap_r_en) cap_r_q <= {cap_r_q[DAC_BITS-2:0], bus.DATAIN};
    end
  end

  dac_serializer #(.WIDTH(DAC_BITS)) u_ser_l (
    .clk   (BCK),
    .rst_n (RSTN),
    .load  (frame_end),
    .word  (word_l),
    .shift (cap_l_en),
    .dout  (dout_l)
  );

  dac_serializer #(.WIDTH(DAC_BITS)) u_ser_r (
    .clk   (BCK),
    .rst_n (RSTN),
    .load  (frame_end),
    .word  (word_r),
    .shift (cap_l_en),
    .dout  (dout_r)
  );

  assign bus.CLKOUTL  = ~BCK;
  assign bus.CLKOUTR  = ~BCK;
  assign bus.DATAOUTL = dout_l;
  assign bus.DATAOUTR = dout_r;
  assign bus.LEOUTL   = le_n_q;
  assign bus.LEOUTR   = le_n_q;
  assign bus.LOCKED   = (good_q == GOOD_MAX);
  assign bus.LED1     = ~bus.LOCKED;

endmodule
